fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 17 +
 rtl/button_conditioner.sv | 58 +++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths and the fetch-stage state encoding.
package fetch_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 12;
  localparam int unsigned OFF_W   = 3;

  typedef enum logic [2:0] {
    EXT,
    EXT_STEP,
    FETCH,
    LATCH,
    READY,
    EXEC
  } fetch_state_t;

endpackage

// File: rtl/button_conditioner.sv
// Raw push-button -> 2-flop synchronizer -> debounced level -> one-cycle press pulse.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_button,
  output logic o_pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  logic             w_level_nxt;
  logic             w_pulse_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Counter only advances while the synchronized input disagrees with the
  // accepted level; any agreement (a bounce) clears it.
  always_comb begin
    w_level_nxt = r_level;
    w_pulse_nxt = 1'b0;
    w_cnt_nxt   = '0;
    if (r_sync2 != r_level) begin
      if (r_cnt == CNT_MAX) begin
        w_level_nxt = r_sync2;
        w_pulse_nxt = r_sync2;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
      r_level <= w_level_nxt;
      r_pulse <= w_pulse_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns pc, imem read, external/internal mode and the step strobe.
module fetch_unit #(
  parameter int unsigned PC_W            = fetch_pkg::PC_W,
  parameter int unsigned INSTR_W         = fetch_pkg::INSTR_W,
  parameter int unsigned OFF_W           = fetch_pkg::OFF_W,
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               left_button,
  input  logic               right_button,
  input  logic [INSTR_W-1:0] switches,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_re,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_taken,
  input  logic [OFF_W-1:0]   branch_offset,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic               step,
  output logic               is_external,
  output logic [PC_W-1:0]    pc
);

  import fetch_pkg::fetch_state_t;

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_nxt;
  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] w_instr_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic               w_left;
  logic               w_right;
  logic [PC_W-1:0]    w_pc_adv;

  button_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_left_btn (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_button (left_button),
    .o_pulse  (w_left)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_right_btn (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_button (right_button),
    .o_pulse  (w_right)
  );

  assign w_pc_adv = r_pc + PC_W'(1) + (branch_taken ? PC_W'(branch_offset) : '0);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    unique case (r_state)
      fetch_pkg::EXT: begin
        w_instr_nxt = switches;
        if (w_right)     w_state_nxt = fetch_pkg::FETCH;
        else if (w_left) w_state_nxt = fetch_pkg::EXT_STEP;
      end
      fetch_pkg::EXT_STEP: w_state_nxt = fetch_pkg::EXT;
      fetch_pkg::FETCH: begin
        w_state_nxt = w_right ? fetch_pkg::EXT : fetch_pkg::LATCH;
      end
      fetch_pkg::LATCH: begin
        // A right press abandons the read; EXT reloads from switches.
        if (w_right) begin
          w_state_nxt = fetch_pkg::EXT;
        end else begin
          w_instr_nxt = imem_rdata;
          w_state_nxt = fetch_pkg::READY;
        end
      end
      fetch_pkg::READY: begin
        if (w_right)     w_state_nxt = fetch_pkg::EXT;
        else if (w_left) w_state_nxt = fetch_pkg::EXEC;
      end
      fetch_pkg::EXEC: begin
        w_pc_nxt    = w_pc_adv;
        w_state_nxt = w_right ? fetch_pkg::EXT : fetch_pkg::FETCH;
      end
      default: w_state_nxt = fetch_pkg::EXT;
    endcase
  end

  // Valid is registered so it reads 0 out of reset even though EXT is the reset state.
  always_comb begin
    w_valid_nxt = 1'b0;
    unique case (w_state_nxt)
      fetch_pkg::EXT, fetch_pkg::EXT_STEP, fetch_pkg::READY, fetch_pkg::EXEC: w_valid_nxt = 1'b1;
      default: w_valid_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= fetch_pkg::EXT;
      r_pc    <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign imem_addr   = r_pc;
  assign imem_re     = (r_state == fetch_pkg::FETCH);
  assign step        = (r_state == fetch_pkg::EXT_STEP) || (r_state == fetch_pkg::EXEC);
  assign is_external = (r_state == fetch_pkg::EXT) || (r_state == fetch_pkg::EXT_STEP);
  assign instruction = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a synchronous imem model and DEBOUNCE_CYCLES = 4.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        left_button, right_button;
  logic [11:0] switches;
  logic [7:0]  imem_addr;
  logic        imem_re;
  logic [11:0] imem_rdata;
  logic        branch_taken;
  logic [2:0]  branch_offset;
  logic [11:0] instruction;
  logic        instr_valid, step, is_external;
  logic [7:0]  pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_W            (8),
    .INSTR_W         (12),
    .OFF_W           (3),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .left_button   (left_button),
    .right_button  (right_button),
    .switches      (switches),
    .imem_addr     (imem_addr),
    .imem_re       (imem_re),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .step          (step),
    .is_external   (is_external),
    .pc            (pc)
  );

  logic [11:0] mem [256];
  always @(posedge clk) if (imem_re) imem_rdata <= mem[imem_addr];

  int          total = 0;
  int          bad = 0;
  int          step_cnt = 0;
  int          viol = 0;
  logic        prev_step = 1'b0;
  logic [11:0] step_instr = '0;
  logic [7:0]  re_addr = '0;
  logic [7:0]  model_pc = '0;

  always @(negedge clk) begin
    if (step) begin
      step_cnt   <= step_cnt + 1;
      step_instr <= instruction;
      if (!instr_valid || prev_step) viol <= viol + 1;
    end
    prev_step <= step;
    if (imem_re) re_addr <= imem_addr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic l, input logic r, input int hold);
    left_button  = l;
    right_button = r;
    repeat (hold) @(negedge clk);
    left_button  = 1'b0;
    right_button = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_step(input logic taken, input logic [2:0] off, input logic [7:0] exp_pc);
    int s0;
    s0 = step_cnt;
    branch_taken  = taken;
    branch_offset = off;
    press(1'b1, 1'b0, 8);
    check("int_step_once", 32'(step_cnt - s0), 1);
    check("int_pc", 32'(pc), 32'(exp_pc));
    check("refetch_addr", 32'(re_addr), 32'(exp_pc));
    check("refetch_instr", 32'(instruction), 32'(mem[exp_pc]));
    check("int_valid", 32'(instr_valid), 1);
    model_pc = exp_pc;
  endtask

  task automatic goto_pc(input logic [7:0] target);
    logic [7:0] diff;
    for (int n = 0; n < 64 && model_pc != target; n++) begin
      diff = target - model_pc;
      if (diff >= 8)      do_step(1'b1, 3'd7, model_pc + 8'd8);
      else if (diff == 1) do_step(1'b0, 3'd0, model_pc + 8'd1);
      else                do_step(1'b1, 3'(diff - 8'd1), target);
    end
  endtask

  typedef struct {
    logic [11:0] sw;
    logic [11:0] exp_instr;
  } ext_vec_t;

  typedef struct {
    logic [7:0] start_pc;
    logic       taken;
    logic [2:0] off;
    logic [7:0] exp_pc;
  } pc_vec_t;

  ext_vec_t evec [4];
  pc_vec_t  pvec [4];

  initial begin
    int  s0;
    logic found;

    evec[0] = '{12'hA05, 12'hA05};
    evec[1] = '{12'h5A0, 12'h5A0};
    evec[2] = '{12'hFFF, 12'hFFF};
    evec[3] = '{12'h000, 12'h000};
    pvec[0] = '{8'd5,   1'b1, 3'd3, 8'd9};
    pvec[1] = '{8'd5,   1'b0, 3'd5, 8'd6};
    pvec[2] = '{8'd255, 1'b0, 3'd2, 8'd0};
    pvec[3] = '{8'd254, 1'b1, 3'd7, 8'd6};
    for (int i = 0; i < 256; i++) mem[i] = 12'h1F3 + 12'(i * 37);

    rst_n = 1'b0;
    left_button = 1'b0; right_button = 1'b0;
    switches = 12'hA05; branch_taken = 1'b0; branch_offset = '0;
    #2;
    check("rst_instr", 32'(instruction), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_ext", 32'(is_external), 1);
    check("rst_re", 32'(imem_re), 0);
    check("rst_step", 32'(step), 0);
    check("rst_pc", 32'(pc), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("boot_instr", 32'(instruction), 32'h A05);
    check("boot_valid", 32'(instr_valid), 1);
    check("boot_ext", 32'(is_external), 1);

    foreach (evec[i]) begin
      switches = evec[i].sw;
      @(negedge clk);
      check("ext_instr", 32'(instruction), 32'(evec[i].exp_instr));
      check("ext_mode", 32'(is_external), 1);
      check("ext_nostep", 32'(step), 0);
    end
    check("ext_step_count", 32'(step_cnt), 0);

    switches = 12'h3C7;
    s0 = step_cnt;
    press(1'b1, 1'b0, 6);
    check("ext_step_once", 32'(step_cnt - s0), 1);
    check("ext_step_instr", 32'(step_instr), 32'h3C7);
    check("ext_step_pc", 32'(pc), 0);

    s0 = step_cnt;
    press(1'b1, 1'b0, 3);
    check("glitch_nostep", 32'(step_cnt - s0), 0);

    right_button = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (imem_re) found = 1'b1;
    end
    check("fetch_seen", 32'(found), 1);
    check("fetch_addr", 32'(imem_addr), 0);
    check("fetch_invalid", 32'(instr_valid), 0);
    @(negedge clk);
    check("fetch_re_1cyc", 32'(imem_re), 0);
    @(negedge clk);
    check("latch_instr", 32'(instruction), 32'h1F3);
    check("latch_valid", 32'(instr_valid), 1);
    check("latch_int", 32'(is_external), 0);
    right_button = 1'b0;
    repeat (12) @(negedge clk);
    model_pc = 8'd0;

    foreach (pvec[i]) begin
      goto_pc(pvec[i].start_pc);
      check("goto_pc", 32'(pc), 32'(pvec[i].start_pc));
      do_step(pvec[i].taken, pvec[i].off, pvec[i].exp_pc);
    end

    // Right arrives one cycle after left: lands in EXEC.
    branch_taken = 1'b0;
    s0 = step_cnt;
    left_button = 1'b1;
    @(negedge clk);
    right_button = 1'b1;
    repeat (8) @(negedge clk);
    left_button = 1'b0; right_button = 1'b0;
    repeat (12) @(negedge clk);
    check("exec_right_step", 32'(step_cnt - s0), 1);
    check("exec_right_pc", 32'(pc), 32'(model_pc + 8'd1));
    check("exec_right_ext", 32'(is_external), 1);
    check("exec_right_instr", 32'(instruction), 32'h3C7);
    model_pc = model_pc + 8'd1;

    press(1'b0, 1'b1, 8);
    check("resume_addr", 32'(re_addr), 32'(model_pc));
    check("resume_instr", 32'(instruction), 32'(mem[model_pc]));
    check("resume_int", 32'(is_external), 0);

    s0 = step_cnt;
    press(1'b0, 1'b1, 8);
    check("ready_right_step", 32'(step_cnt - s0), 0);
    check("ready_right_ext", 32'(is_external), 1);
    check("ready_right_pc", 32'(pc), 32'(model_pc));
    press(1'b0, 1'b1, 8);
    check("resume2_int", 32'(is_external), 0);

    s0 = step_cnt;
    press(1'b1, 1'b1, 8);
    check("both_nostep", 32'(step_cnt - s0), 0);
    check("both_ext", 32'(is_external), 1);
    check("both_pc", 32'(pc), 32'(model_pc));
    check("both_instr", 32'(instruction), 32'h3C7);

    press(1'b0, 1'b1, 8);
    left_button = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (imem_re) found = 1'b1;
    end
    check("midfetch_seen", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_pc", 32'(pc), 0);
    check("midrst_instr", 32'(instruction), 0);
    check("midrst_valid", 32'(instr_valid), 0);
    check("midrst_re", 32'(imem_re), 0);
    check("midrst_addr", 32'(imem_addr), 0);
    check("midrst_step", 32'(step), 0);
    check("midrst_ext", 32'(is_external), 1);
    s0 = step_cnt;
    left_button = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("postrst_nostep", 32'(step_cnt - s0), 0);
    check("postrst_instr", 32'(instruction), 32'h3C7);

    check("step_invariants", 32'(viol), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
